// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes, FSM states, tag width.
// No logic here.
// No backpressure here; consumers import these types.
package muldiv_pkg;

    localparam int CSU_SIZE_BITS = 5;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring unsigned divider producing quotient and remainder.
// Latency: XLEN enabled cycles after start; done flags the final iteration cycle.
// Backpressure: en low freezes all state; abort drops the operation.
module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            en,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dsr;
    logic [XLEN:0]    shifted;
    logic [XLEN-1:0]  diff;
    logic             ge;

    // The dividend shifts out of the quotient register while quotient bits shift in.
    assign shifted = {remainder, quotient[XLEN-1]};
    assign ge      = shifted >= {1'b0, dsr};
    assign diff    = shifted[XLEN-1:0] - dsr;
    assign done    = busy && (cnt == '0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (en) begin
            if (start) begin
                busy      <= 1'b1;
                cnt       <= CNT_W'(XLEN - 1);
                dsr       <= divisor;
                quotient  <= dividend;
                remainder <= '0;
            end else if (busy) begin
                remainder <= ge ? diff : shifted[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], ge};
                cnt       <= cnt - 1'b1;
                if (cnt == '0) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one op at a time, result held until acknowledged.
// Latency: MUL_STAGES for multiplies, XLEN+1 for divides, 1 for divide-by-zero/overflow.
// Backpressure: rdy_in low freezes everything; result held in DONE until rdy_in & out_ack.
module muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int CSU_SIZE_BITS = muldiv_pkg::CSU_SIZE_BITS,
    parameter int MUL_STAGES    = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_pipline,
    input  logic                     have_ins,
    output logic                     in_ready,
    input  logic [CSU_SIZE_BITS-1:0] ins_id,
    input  logic [XLEN-1:0]          rs1_val,
    input  logic [XLEN-1:0]          rs2_val,
    input  logic [2:0]               funct3,
    output logic                     muldiv_rdy,
    output logic [XLEN-1:0]          muldiv_res,
    output logic [CSU_SIZE_BITS-1:0] res_ins_id,
    input  logic                     out_ack
);

    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(XLEN > MUL_STAGES ? XLEN : MUL_STAGES);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t           state;
    logic [CNT_W-1:0]        cnt;
    logic [XLEN-1:0]         op_a;
    logic [XLEN-1:0]         op_b;
    logic [2:0]              op_f3;
    logic [CSU_SIZE_BITS-1:0] op_id;
    logic                    special;
    logic [XLEN-1:0]         spec_res;

    logic                    signed_div;
    logic                    div_zero;
    logic                    div_ovf;
    logic                    div_start;
    logic [XLEN-1:0]         dvd_mag;
    logic [XLEN-1:0]         dsr_mag;
    logic                    div_busy;
    logic                    div_done;
    logic [XLEN-1:0]         div_quo;
    logic [XLEN-1:0]         div_rem;

    logic [2*XLEN-1:0]       a_ext;
    logic [2*XLEN-1:0]       b_ext;
    logic [2*XLEN-1:0]       prod;
    logic [XLEN-1:0]         mul_res;
    logic [XLEN-1:0]         fix_res;

    assign in_ready   = (state == ST_IDLE);
    assign signed_div = (funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM);
    assign div_zero   = (rs2_val == '0);
    assign div_ovf    = signed_div && (rs1_val == XMIN) && (rs2_val == '1);
    assign dvd_mag    = (signed_div && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    assign dsr_mag    = (signed_div && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    assign div_start  = rdy_in && have_ins && in_ready && !flush_pipline
                        && funct3[2] && !div_zero && !div_ovf;

    // Sign-extend to full product width so one unsigned multiply covers all three signedness modes.
    assign a_ext   = {{XLEN{op_a[XLEN-1] && (op_f3 == MULDIV_MULH || op_f3 == MULDIV_MULHSU)}}, op_a};
    assign b_ext   = {{XLEN{op_b[XLEN-1] && (op_f3 == MULDIV_MULH)}}, op_b};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op_f3 == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = div_quo;
        if (op_f3[1]) begin
            fix_res = (op_f3 == MULDIV_REM && op_a[XLEN-1]) ? -div_rem : div_rem;
        end else if (op_f3 == MULDIV_DIV && (op_a[XLEN-1] ^ op_b[XLEN-1])) begin
            fix_res = -div_quo;
        end
    end

    muldiv_divider #(.XLEN(XLEN)) u_divider (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .start     (div_start),
        .abort     (flush_pipline),
        .dividend  (dvd_mag),
        .divisor   (dsr_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_f3      <= '0;
            op_id      <= '0;
            special    <= 1'b0;
            spec_res   <= '0;
            muldiv_rdy <= 1'b0;
            muldiv_res <= '0;
            res_ins_id <= '0;
        end else if (flush_pipline) begin
            state      <= ST_IDLE;
            muldiv_rdy <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (have_ins) begin
                        op_a  <= rs1_val;
                        op_b  <= rs2_val;
                        op_f3 <= funct3;
                        op_id <= ins_id;
                        if (!funct3[2]) begin
                            state <= ST_MUL;
                            cnt   <= CNT_W'(MUL_STAGES - 1);
                        end else if (div_zero || div_ovf) begin
                            // Shortcut results still take one registered pass through FIX.
                            state    <= ST_FIX;
                            special  <= 1'b1;
                            spec_res <= funct3[1] ? (div_zero ? rs1_val : '0)
                                                  : (div_zero ? '1 : XMIN);
                        end else begin
                            state   <= ST_DIV;
                            special <= 1'b0;
                            cnt     <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        state      <= ST_DONE;
                        muldiv_res <= mul_res;
                        res_ins_id <= op_id;
                        muldiv_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt - 1'b1;
                    if (div_done || !div_busy) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state      <= ST_DONE;
                    muldiv_res <= special ? spec_res : fix_res;
                    res_ins_id <= op_id;
                    muldiv_rdy <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ack) begin
                        state      <= ST_IDLE;
                        muldiv_rdy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with cycle-level latency tracking,
// directed spot checks followed by a randomized handshake/stall/flush phase.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int MS   = 2;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        have_ins;
    logic        in_ready;
    logic [4:0]  ins_id;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [2:0]  funct3;
    logic        muldiv_rdy;
    logic [31:0] muldiv_res;
    logic [4:0]  res_ins_id;
    logic        out_ack;

    muldiv_unit #(.XLEN(XLEN), .CSU_SIZE_BITS(5), .MUL_STAGES(MS)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .have_ins      (have_ins),
        .in_ready      (in_ready),
        .ins_id        (ins_id),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .funct3        (funct3),
        .muldiv_rdy    (muldiv_rdy),
        .muldiv_res    (muldiv_res),
        .res_ins_id    (res_ins_id),
        .out_ack       (out_ack)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MS;
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 300);
            6: return -$urandom_range(1, 300);
            default: return $urandom;
        endcase
    endfunction

    // Reference model: occupancy, remaining latency and expected result.
    bit          m_busy;
    bit          m_rdy;
    int          m_cnt;
    logic [31:0] m_res;
    logic [4:0]  m_id;
    int          n_results = 0;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_busy = 0;
            m_rdy  = 0;
            m_cnt  = 0;
        end else if (flush_pipline) begin
            m_busy = 0;
            m_rdy  = 0;
        end else if (rdy_in) begin
            if (!m_busy) begin
                if (have_ins) begin
                    m_busy = 1;
                    m_res  = ref_op(funct3, rs1_val, rs2_val);
                    m_id   = ins_id;
                    m_cnt  = ref_lat(funct3, rs1_val, rs2_val);
                end
            end else if (!m_rdy) begin
                m_cnt--;
                if (m_cnt == 0) m_rdy = 1;
            end else if (out_ack) begin
                m_busy = 0;
                m_rdy  = 0;
                n_results++;
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
            chk("muldiv_rdy", {31'b0, muldiv_rdy}, {31'b0, m_rdy});
            if (m_rdy && muldiv_rdy) begin
                chk("muldiv_res", muldiv_res, m_res);
                chk("res_ins_id", {27'b0, res_ins_id}, {27'b0, m_id});
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] id, input logic [31:0] exp_v, input int exp_lat,
                          input string nm, input int stall_at, input int stall_len, input int hold);
        int g;
        int cyc;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk_in); #1; g++;
        end
        have_ins = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; ins_id = id;
        @(posedge clk_in); #1;
        have_ins = 1'b0; rs1_val = $urandom; rs2_val = $urandom; ins_id = 5'($urandom);
        cyc = 0;
        while (!muldiv_rdy && cyc < 200) begin
            if (cyc == stall_at) rdy_in = 1'b0;
            if (cyc == stall_at + stall_len) rdy_in = 1'b1;
            @(posedge clk_in); #1; cyc++;
        end
        rdy_in = 1'b1;
        chk({nm, " latency"}, cyc, exp_lat);
        chk({nm, " result"}, muldiv_res, exp_v);
        chk({nm, " tag"}, {27'b0, res_ins_id}, {27'b0, id});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_in); #1;
            chk({nm, " hold rdy"}, {31'b0, muldiv_rdy}, 32'd1);
            chk({nm, " hold res"}, muldiv_res, exp_v);
            chk({nm, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ack = 1'b1;
        @(posedge clk_in); #1;
        out_ack = 1'b0;
        chk({nm, " in_ready after ack"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0; have_ins = 1'b0;
        ins_id = '0; rs1_val = '0; rs2_val = '0; funct3 = '0; out_ack = 1'b0;
        #3;
        chk("reset rdy", {31'b0, muldiv_rdy}, 32'd0);
        chk("reset res", muldiv_res, 32'd0);
        chk("reset tag", {27'b0, res_ins_id}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk_in);
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1;

        run_op(3'd0, 32'd7, -32'd3, 5'd5, 32'hFFFF_FFEB, MS, "MUL 7x-3", -1, 0, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, MS, "MULH", -1, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, MS, "MULHSU", -1, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, MS, "MULHU", -1, 0, 0);
        run_op(3'd4, -32'd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, "DIV -7/2", -1, 0, 0);
        run_op(3'd6, -32'd7, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, "REM -7/2", -1, 0, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, "DIVU 100/7", -1, 0, 0);
        run_op(3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "DIVU 5/0", -1, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 1, "REM ovf", -1, 0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, "DIV ovf", -1, 0, 0);
        run_op(3'd4, 32'd1000, -32'd7, 5'd11, 32'hFFFF_FF72, 37, "DIV stalled", 5, 4, 10);

        // Flush ten cycles into a divide while a new issue is offered.
        have_ins = 1'b1; funct3 = 3'd4; rs1_val = 32'd12345; rs2_val = 32'd17; ins_id = 5'd12;
        @(posedge clk_in); #1;
        have_ins = 1'b0;
        repeat (10) begin @(posedge clk_in); #1; end
        flush_pipline = 1'b1; have_ins = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3;
        @(posedge clk_in); #1;
        flush_pipline = 1'b0; have_ins = 1'b0;
        chk("flush in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush rdy", {31'b0, muldiv_rdy}, 32'd0);
        repeat (40) begin @(posedge clk_in); #1; end
        chk("flush no result", {31'b0, muldiv_rdy}, 32'd0);

        // Asynchronous reset in the middle of a multiply.
        have_ins = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; ins_id = 5'd13;
        @(posedge clk_in); #1;
        have_ins = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        chk("async reset rdy", {31'b0, muldiv_rdy}, 32'd0);
        chk("async reset res", muldiv_res, 32'd0);
        chk("async reset tag", {27'b0, res_ins_id}, 32'd0);
        chk("async reset in_ready", {31'b0, in_ready}, 32'd1);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;

        for (int c = 0; c < 4000; c++) begin
            rdy_in        = ($urandom_range(0, 7) != 0);
            have_ins      = 1'($urandom_range(0, 1));
            flush_pipline = ($urandom_range(0, 63) == 0);
            out_ack       = ($urandom_range(0, 2) == 0);
            funct3        = 3'($urandom_range(0, 7));
            rs1_val       = rnd_val();
            rs2_val       = rnd_val();
            ins_id        = 5'($urandom_range(0, 31));
            @(posedge clk_in); #1;
        end
        have_ins = 1'b0; flush_pipline = 1'b0; rdy_in = 1'b1; out_ack = 1'b1;
        repeat (50) begin @(posedge clk_in); #1; end
        chk("random results delivered", {31'b0, n_results >= 20}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
